// File: rtl/tcp_pkg.sv
// Shared TCP definitions: flag bit indices, field widths and the request slot record.
package tcp_pkg;

    localparam int unsigned SEQ_W  = 32;
    localparam int unsigned FLAG_W = 8;
    localparam int unsigned SIZE_W = 16;

    localparam int unsigned FLAG_CWR = 0;
    localparam int unsigned FLAG_ECE = 1;
    localparam int unsigned FLAG_URG = 2;
    localparam int unsigned FLAG_ACK = 3;
    localparam int unsigned FLAG_PSH = 4;
    localparam int unsigned FLAG_RST = 5;
    localparam int unsigned FLAG_SYN = 6;
    localparam int unsigned FLAG_FIN = 7;

    localparam logic [3:0] TCP_HDR_DOFF = 4'd5;

    typedef struct packed {
        logic [FLAG_W-1:0] flag;
        logic [SEQ_W-1:0]  seq;
        logic [SEQ_W-1:0]  ack;
        logic [SIZE_W-1:0] size;
        logic [15:0]       src_port;
        logic [15:0]       dst_port;
        logic [15:0]       window;
    } tcp_req_t;

    // Internal flag indices do not match the on-wire bit order (CWR is wire bit 7).
    function automatic logic [7:0] tcp_wire_flags(input logic [FLAG_W-1:0] f);
        logic [7:0] w;
        w    = '0;
        w[7] = f[FLAG_CWR];
        w[6] = f[FLAG_ECE];
        w[5] = f[FLAG_URG];
        w[4] = f[FLAG_ACK];
        w[3] = f[FLAG_PSH];
        w[2] = f[FLAG_RST];
        w[1] = f[FLAG_SYN];
        w[0] = f[FLAG_FIN];
        return w;
    endfunction

endpackage

// File: rtl/tcp_req_slot.sv
// One registered send-request slot: capture loads and sets valid, clear drops valid.
module tcp_req_slot
    import tcp_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     cap_i,
    input  logic     clr_i,
    input  tcp_req_t d_i,
    output logic     v_o,
    output tcp_req_t q_o
);

    logic     v_q, v_d;
    tcp_req_t q_q, q_d;

    always_comb begin
        v_d = v_q;
        q_d = q_q;
        if (cap_i) begin
            v_d = 1'b1;
            q_d = d_i;
        end else if (clr_i) begin
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= 1'b0;
            q_q <= '0;
        end else begin
            v_q <= v_d;
            q_q <= q_d;
        end
    end

    assign v_o = v_q;
    assign q_o = q_q;

endmodule

// File: rtl/tcp_tx_hdr.sv
// Serialises a 20-byte TCP header onto a 64-bit stream in three beats,
// with one active and one pending request slot.
module tcp_tx_hdr
    import tcp_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned KEEP_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_v_i,
    input  logic [7:0]        req_flag_i,
    input  logic [31:0]       req_seq_i,
    input  logic [31:0]       req_ack_i,
    input  logic [15:0]       req_size_i,
    input  logic [15:0]       cfg_src_port_i,
    input  logic [15:0]       cfg_dst_port_i,
    input  logic [15:0]       cfg_window_i,
    output logic              data_v_o,
    output logic [DATA_W-1:0] data_o,
    output logic [KEEP_W-1:0] keep_o,
    output logic              last_o,
    input  logic              ready_i,
    output logic              sent_v_o,
    output logic [15:0]       sent_size_o,
    output logic              overflow_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_B0, ST_B1, ST_B2} state_e;

    state_e   state_q, state_d;
    tcp_req_t req_now, act_d, act_q, pend_q;
    logic     act_v, act_cap, act_clr;
    logic     pend_v, pend_cap, pend_clr;
    logic     ovf_q, ovf_d;
    logic     hs_last;

    assign req_now = '{flag: req_flag_i, seq: req_seq_i, ack: req_ack_i, size: req_size_i,
                       src_port: cfg_src_port_i, dst_port: cfg_dst_port_i,
                       window: cfg_window_i};
    assign hs_last = (state_q == ST_B2) && ready_i;

    tcp_req_slot u_act (
        .clk(clk), .reset(reset), .cap_i(act_cap), .clr_i(act_clr),
        .d_i(act_d), .v_o(act_v), .q_o(act_q)
    );

    tcp_req_slot u_pend (
        .clk(clk), .reset(reset), .cap_i(pend_cap), .clr_i(pend_clr),
        .d_i(req_now), .v_o(pend_v), .q_o(pend_q)
    );

    always_comb begin
        state_d  = state_q;
        act_d    = req_now;
        act_cap  = 1'b0;
        act_clr  = 1'b0;
        pend_cap = 1'b0;
        pend_clr = 1'b0;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: if (req_v_i) begin
                act_cap = 1'b1;
                state_d = ST_B0;
            end
            ST_B0:   if (ready_i) state_d = ST_B1;
            ST_B1:   if (ready_i) state_d = ST_B2;
            ST_B2:   if (ready_i) state_d = (pend_v || req_v_i) ? ST_B0 : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // On the final handshake pend promotes to act and the slot refills in the same cycle.
        if (state_q != ST_IDLE) begin
            if (hs_last) begin
                if (pend_v) begin
                    act_cap = 1'b1;
                    act_d   = pend_q;
                    if (req_v_i) pend_cap = 1'b1;
                    else         pend_clr = 1'b1;
                end else if (req_v_i) begin
                    act_cap = 1'b1;
                end else begin
                    act_clr = 1'b1;
                end
            end else if (req_v_i) begin
                if (!pend_v) pend_cap = 1'b1;
                else         ovf_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        data_o = '0;
        keep_o = '0;
        last_o = 1'b0;
        case (state_q)
            ST_B0: begin
                data_o = {act_q.seq[7:0], act_q.seq[15:8], act_q.seq[23:16], act_q.seq[31:24],
                          act_q.dst_port[7:0], act_q.dst_port[15:8],
                          act_q.src_port[7:0], act_q.src_port[15:8]};
                keep_o = '1;
            end
            ST_B1: begin
                data_o = {act_q.window[7:0], act_q.window[15:8], tcp_wire_flags(act_q.flag),
                          TCP_HDR_DOFF, 4'h0,
                          act_q.ack[7:0], act_q.ack[15:8], act_q.ack[23:16], act_q.ack[31:24]};
                keep_o = '1;
            end
            ST_B2: begin
                keep_o = 8'h0F;
                last_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign data_v_o    = (state_q != ST_IDLE);
    assign sent_v_o    = hs_last && act_v;
    assign sent_size_o = act_q.size;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_tcp_tx_hdr.sv
// Bench for tcp_tx_hdr: directed scenarios plus random traffic, checked
// against a segment-queue / header-byte-array reference model.
module tb_tcp_tx_hdr;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_v_i;
    logic [7:0]  req_flag_i;
    logic [31:0] req_seq_i, req_ack_i;
    logic [15:0] req_size_i, cfg_src_port_i, cfg_dst_port_i, cfg_window_i;
    logic        data_v_o, last_o, ready_i, sent_v_o, overflow_o;
    logic [63:0] data_o;
    logic [7:0]  keep_o;
    logic [15:0] sent_size_o;

    tcp_tx_hdr #(.DATA_W(64), .KEEP_W(8)) dut (
        .clk(clk), .reset(reset), .req_v_i(req_v_i), .req_flag_i(req_flag_i),
        .req_seq_i(req_seq_i), .req_ack_i(req_ack_i), .req_size_i(req_size_i),
        .cfg_src_port_i(cfg_src_port_i), .cfg_dst_port_i(cfg_dst_port_i),
        .cfg_window_i(cfg_window_i), .data_v_o(data_v_o), .data_o(data_o),
        .keep_o(keep_o), .last_o(last_o), .ready_i(ready_i), .sent_v_o(sent_v_o),
        .sent_size_o(sent_size_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  flag;
        logic [31:0] seq, ack;
        logic [15:0] size, src, dst, win;
    } seg_t;

    seg_t        mq[$];
    int          beat;
    logic        m_ovf;
    int          checks = 0;
    int          errors = 0;
    int          sent_cnt;
    logic [15:0] sent_sizes[$];
    logic [63:0] obs_data;
    logic [7:0]  obs_keep;
    logic        obs_v;

    function automatic logic [7:0] hdr_byte(seg_t s, int idx);
        logic [7:0] h[20];
        for (int i = 0; i < 20; i++) h[i] = 8'h00;
        h[0] = s.src[15:8]; h[1] = s.src[7:0];
        h[2] = s.dst[15:8]; h[3] = s.dst[7:0];
        for (int i = 0; i < 4; i++) begin
            h[4 + i] = s.seq[31 - 8*i -: 8];
            h[8 + i] = s.ack[31 - 8*i -: 8];
        end
        h[12] = 8'h50;
        for (int i = 0; i < 8; i++) h[13][7 - i] = s.flag[i];
        h[14] = s.win[15:8]; h[15] = s.win[7:0];
        return (idx < 20) ? h[idx] : 8'h00;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rand_fields();
        req_flag_i     = 8'($urandom);
        req_seq_i      = $urandom;
        req_ack_i      = $urandom;
        req_size_i     = 16'($urandom);
        cfg_src_port_i = 16'($urandom);
        cfg_dst_port_i = 16'($urandom);
        cfg_window_i   = 16'($urandom);
    endtask

    // Called at posedge+1; samples mid-cycle, then applies the model update at the next edge.
    task automatic cycle(input logic rq, input logic rdy, input logic rst);
        logic [63:0] ed;
        logic [7:0]  ek;
        logic        ev, el, es, acc;
        seg_t        s;
        req_v_i = rq;
        ready_i = rdy;
        reset   = rst;
        #4;
        ed = '0; ek = '0; ev = 1'b0; el = 1'b0; es = 1'b0;
        if (mq.size() > 0) begin
            ev = 1'b1;
            for (int i = 0; i < 8; i++) begin
                ed[8*i +: 8] = hdr_byte(mq[0], 8*beat + i);
                ek[i]        = (8*beat + i) < 20;
            end
            el = (beat == 2);
            es = (beat == 2) && rdy;
        end
        chk("data_v", 64'(data_v_o), 64'(ev));
        chk("data", data_o, ed);
        chk("keep", 64'(keep_o), 64'(ek));
        chk("last", 64'(last_o), 64'(el));
        chk("sent_v", 64'(sent_v_o), 64'(es));
        chk("overflow", 64'(overflow_o), 64'(m_ovf));
        if (es) chk("sent_size", 64'(sent_size_o), 64'(mq[0].size));
        obs_data = data_o;
        obs_keep = keep_o;
        obs_v    = data_v_o;
        if (sent_v_o) begin
            sent_cnt++;
            sent_sizes.push_back(sent_size_o);
        end
        s = '{flag: req_flag_i, seq: req_seq_i, ack: req_ack_i, size: req_size_i,
              src: cfg_src_port_i, dst: cfg_dst_port_i, win: cfg_window_i};
        @(posedge clk);
        if (rst) begin
            mq.delete();
            beat  = 0;
            m_ovf = 1'b0;
        end else begin
            acc = (mq.size() < 2) || (beat == 2 && rdy);
            if (mq.size() > 0 && rdy) begin
                if (beat == 2) begin
                    void'(mq.pop_front());
                    beat = 0;
                end else begin
                    beat++;
                end
            end
            if (rq) begin
                if (acc) mq.push_back(s);
                else     m_ovf = 1'b1;
            end
        end
        #1;
        req_v_i = 1'b0;
        reset   = 1'b0;
    endtask

    task automatic syn_fields();
        req_flag_i = 8'h40; req_seq_i = 32'h12345678; req_ack_i = 32'h0; req_size_i = 16'd0;
        cfg_src_port_i = 16'h1F90; cfg_dst_port_i = 16'h0050; cfg_window_i = 16'hFFFF;
    endtask

    initial begin
        reset = 1'b1; req_v_i = 1'b0; ready_i = 1'b1;
        beat = 0; m_ovf = 1'b0; sent_cnt = 0;
        rand_fields();
        @(posedge clk);
        #1;
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);

        // SYN header with ready held high
        syn_fields();
        sent_cnt = 0;
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("syn_b0", obs_data, 64'h78563412_5000901F);
        cycle(1'b0, 1'b1, 1'b0);
        chk("syn_b1", obs_data, 64'hFFFF0250_00000000);
        cycle(1'b0, 1'b1, 1'b0);
        chk("syn_b2_keep", 64'(obs_keep), 64'h0F);
        chk("syn_sent_n3", 64'(sent_cnt), 64'd1);
        cycle(1'b0, 1'b1, 1'b0);

        // Backpressure on B1
        sent_cnt = 0;
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            chk("bp_b1_hold", obs_data, 64'hFFFF0250_00000000);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
        chk("bp_sent_once", 64'(sent_cnt), 64'd1);

        // ACK then FIN|ACK, back to back
        sent_cnt = 0; sent_sizes.delete();
        req_flag_i = 8'h08; req_size_i = 16'd100; req_seq_i = 32'hA0A0_0001; req_ack_i = 32'h0BAD_F00D;
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        req_flag_i = 8'h88; req_size_i = 16'd0; req_seq_i = 32'hA0A0_0065;
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("no_bubble", 64'(obs_v), 64'd1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
        chk("b2b_sent_n", 64'(sent_cnt), 64'd2);
        if (sent_sizes.size() == 2) begin
            chk("b2b_size0", 64'(sent_sizes[0]), 64'd100);
            chk("b2b_size1", 64'(sent_sizes[1]), 64'd0);
        end

        // Three requests on consecutive cycles: third dropped
        sent_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            rand_fields();
            cycle(1'b1, 1'b1, 1'b0);
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0);
        chk("ovf_set", 64'(overflow_o), 64'd1);
        chk("ovf_two_hdrs", 64'(sent_cnt), 64'd2);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
        chk("ovf_sticky", 64'(overflow_o), 64'd1);

        // Request on B2 handshake with pend full: no drop, order kept
        cycle(1'b0, 1'b1, 1'b1);
        sent_sizes.delete();
        rand_fields(); req_size_i = 16'd1;
        cycle(1'b1, 1'b1, 1'b0);
        rand_fields(); req_size_i = 16'd2;
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        rand_fields(); req_size_i = 16'd3;
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0);
        chk("hs_no_ovf", 64'(overflow_o), 64'd0);
        chk("hs_sent_n", 64'(sent_sizes.size()), 64'd3);
        if (sent_sizes.size() == 3) begin
            chk("hs_order0", 64'(sent_sizes[0]), 64'd1);
            chk("hs_order1", 64'(sent_sizes[1]), 64'd2);
            chk("hs_order2", 64'(sent_sizes[2]), 64'd3);
        end

        // Reset during B1 abandons the header
        sent_cnt = 0;
        rand_fields();
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        chk("rst_idle_v", 64'(obs_v), 64'd0);
        chk("rst_no_sent", 64'(sent_cnt), 64'd0);
        rand_fields();
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0);
        chk("rst_new_hdr", 64'(sent_cnt), 64'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rand_fields();
            cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 99) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
